hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RV32I core. It detects load-use and other non-ALU-result hazards that EX/MEM forwarding cannot cover, and resolves branch and jump redirects from EX. It also freezes the pipeline while a multi-cycle data-memory access is pending in MEM. It drives the stall and flush enables of the PC and pipeline registers, and keeps saturating performance counters plus a sticky memory-timeout error.

---
 rtl/hazard_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// rv32_pkg / hazard_ctrl
//
// Pipeline hazard and stall controller for the 5-stage RV32I core.
//   * Detects hazards that EX/MEM forwarding cannot cover. These are
//     non-ALU results in EX consumed by the ID instruction, and they cost
//     2 stall cycles.
//   * Resolves taken branch / jump redirects from EX by flushing IF/ID and
//     ID/EX.
//   * Freezes the whole pipeline while a data-memory access in MEM is
//     waiting. A wait that lasts too long parks the controller in a sticky
//     error state.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   inst_ID, inst_EX     instructions currently in ID and EX
//   RegWEn_EX, WBSel_EX  write-back enable / source of the EX instruction
//   PCSel_EX             redirect (taken branch, JAL, JALR) resolved in EX
//   mem_req_MEM          MEM instruction is accessing dmem
//   mem_ready            dmem completes the access this cycle
//   stall_*              hold PC / pipeline registers
//   flush_IF_ID/ID_EX    load a NOP on the next edge
//   bubble_MEM_WB        load a NOP into MEM/WB
//   state                00 RUN, 01 LU_HOLD, 10 MEM_WAIT, 11 ERR
//   *_cnt                saturating performance counters
//   mem_err              sticky memory timeout
// ---------------------------------------------------------------------------
package rv32_pkg;
    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC  = 2'd2,
        WB_CSR = 2'd3
    } WBSel_t;
endpackage

module hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            inst_ID,
    input  logic [31:0]            inst_EX,
    input  logic                   RegWEn_EX,
    input  rv32_pkg::WBSel_t       WBSel_EX,
    input  logic                   PCSel_EX,
    input  logic                   mem_req_MEM,
    input  logic                   mem_ready,
    output logic                   stall_PC,
    output logic                   stall_IF_ID,
    output logic                   stall_ID_EX,
    output logic                   stall_EX_MEM,
    output logic                   flush_IF_ID,
    output logic                   flush_ID_EX,
    output logic                   bubble_MEM_WB,
    output logic [1:0]             state,
    output logic [CNT_W-1:0]       lu_stall_cnt,
    output logic [CNT_W-1:0]       mem_stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt,
    output logic                   mem_err
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_LU_HOLD  = 2'b01,
        S_MEM_WAIT = 2'b10,
        S_ERR      = 2'b11
    } state_t;

    state_t             state_q, state_d;
    state_t             ret_q, ret_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0]   mem_cnt_q, mem_cnt_d;
    logic [CNT_W-1:0]   fl_cnt_q, fl_cnt_d;
    logic               mem_err_q, mem_err_d;

    // Field extraction and source-usage decode
    logic [4:0] rd_ex, rs1_id, rs2_id;
    logic [6:0] op_id;
    logic       use_rs1, use_rs2, hz, mw;
    logic       unused_bits;

    assign rd_ex  = inst_EX[11:7];
    assign rs1_id = inst_ID[19:15];
    assign rs2_id = inst_ID[24:20];
    assign op_id  = inst_ID[6:0];
    assign unused_bits = ^{inst_ID[31:25], inst_ID[14:7], inst_EX[31:12], inst_EX[6:0]};

    assign use_rs1 = (op_id != OP_LUI) && (op_id != OP_AUIPC) && (op_id != OP_JAL);
    assign use_rs2 = (op_id == OP_RTYPE) || (op_id == OP_STORE) || (op_id == OP_BRANCH);

    assign hz = RegWEn_EX && (WBSel_EX != rv32_pkg::WB_ALU) && (rd_ex != 5'd0) &&
                ((use_rs1 && (rd_ex == rs1_id)) || (use_rs2 && (rd_ex == rs2_id)));
    assign mw = mem_req_MEM && !mem_ready;

    // Stall / flush / bubble decode, combinational from inputs and state
    logic s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, b_memwb, lu_stall;

    always_comb begin
        s_pc     = 1'b0;
        s_ifid   = 1'b0;
        s_idex   = 1'b0;
        s_exmem  = 1'b0;
        f_ifid   = 1'b0;
        f_idex   = 1'b0;
        b_memwb  = 1'b0;
        lu_stall = 1'b0;
        if (state_q == S_ERR || mw) begin
            s_pc    = 1'b1;
            s_ifid  = 1'b1;
            s_idex  = 1'b1;
            s_exmem = 1'b1;
            b_memwb = 1'b1;
        end else if (PCSel_EX) begin
            // The ID instruction is wrong-path, so a coincident hazard is moot.
            f_ifid = 1'b1;
            f_idex = 1'b1;
        end else if ((state_q == S_RUN && hz) || state_q == S_LU_HOLD) begin
            s_pc     = 1'b1;
            s_ifid   = 1'b1;
            f_idex   = 1'b1;
            lu_stall = 1'b1;
        end
    end

    // Outputs are forced low for as long as reset is held.
    assign stall_PC      = rst_n & s_pc;
    assign stall_IF_ID   = rst_n & s_ifid;
    assign stall_ID_EX   = rst_n & s_idex;
    assign stall_EX_MEM  = rst_n & s_exmem;
    assign flush_IF_ID   = rst_n & f_ifid;
    assign flush_ID_EX   = rst_n & f_idex;
    assign bubble_MEM_WB = rst_n & b_memwb;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        case (state_q)
            S_RUN: begin
                if (mw) begin
                    state_d = S_MEM_WAIT;
                    ret_d   = S_RUN;
                end else if (!PCSel_EX && hz) begin
                    state_d = S_LU_HOLD;
                end
            end
            S_LU_HOLD: begin
                if (mw) begin
                    state_d = S_MEM_WAIT;
                    ret_d   = S_LU_HOLD;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_MEM_WAIT: begin
                if (!mw) begin
                    state_d = ret_q;
                end else if (timer_q == TMR_W'(MEM_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end
            end
            default: state_d = S_ERR;
        endcase
    end

    // Timer counts consecutive mw cycles in every state and saturates.
    always_comb begin
        timer_d = '0;
        if (mw) begin
            timer_d = (timer_q == {TMR_W{1'b1}}) ? timer_q : timer_q + 1'b1;
        end
    end

    assign mem_err_d = mem_err_q | (state_d == S_ERR);

    always_comb begin
        lu_cnt_d  = lu_cnt_q;
        mem_cnt_d = mem_cnt_q;
        fl_cnt_d  = fl_cnt_q;
        if (lu_stall && lu_cnt_q != {CNT_W{1'b1}}) begin
            lu_cnt_d = lu_cnt_q + 1'b1;
        end
        if (mw && state_q != S_ERR && mem_cnt_q != {CNT_W{1'b1}}) begin
            mem_cnt_d = mem_cnt_q + 1'b1;
        end
        if (f_ifid && fl_cnt_q != {CNT_W{1'b1}}) begin
            fl_cnt_d = fl_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            ret_q     <= S_RUN;
            timer_q   <= '0;
            lu_cnt_q  <= '0;
            mem_cnt_q <= '0;
            fl_cnt_q  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            timer_q   <= timer_d;
            lu_cnt_q  <= lu_cnt_d;
            mem_cnt_q <= mem_cnt_d;
            fl_cnt_q  <= fl_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign state         = state_q;
    assign lu_stall_cnt  = lu_cnt_q;
    assign mem_stall_cnt = mem_cnt_q;
    assign flush_cnt     = fl_cnt_q;
    assign mem_err       = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int CNT_W       = 2;
    localparam int MEM_TIMEOUT = 4;

    // Output patterns {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
    //                  flush_IF_ID, flush_ID_EX, bubble_MEM_WB}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_HZ   = 7'b1100010;
    localparam logic [6:0] O_MW   = 7'b1111001;
    localparam logic [6:0] O_FL   = 7'b0000110;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [31:0] LW_X5      = 32'h0000_A283;
    localparam logic [31:0] LW_X0      = 32'h0000_A003;
    localparam logic [31:0] ADD_6_5_1  = 32'h0012_8333;
    localparam logic [31:0] ADD_6_1_5  = 32'h0050_8333;
    localparam logic [31:0] ADD_1_0_0  = 32'h0000_00B3;
    localparam logic [31:0] LUI_X5     = 32'h0002_82B7;
    localparam logic [31:0] AUIPC_X5   = 32'h0002_8297;
    localparam logic [31:0] JAL_X5     = 32'h0002_82EF;
    localparam logic [31:0] JALR_6_5   = 32'h0002_8367;
    localparam logic [31:0] ADDI_6_5_1 = 32'h0012_8313;
    localparam logic [31:0] ADDI_6_1_5 = 32'h0050_8313;
    localparam logic [31:0] SW_5_1     = 32'h0050_A023;
    localparam logic [31:0] BEQ_1_5    = 32'h0050_8063;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] inst_ID = NOP, inst_EX = NOP;
    logic RegWEn_EX = 1'b0;
    rv32_pkg::WBSel_t WBSel_EX = rv32_pkg::WB_ALU;
    logic PCSel_EX = 1'b0, mem_req_MEM = 1'b0, mem_ready = 1'b0;
    logic stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
    logic flush_IF_ID, flush_ID_EX, bubble_MEM_WB;
    logic [1:0] state;
    logic [CNT_W-1:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;
    logic mem_err;
    logic [6:0] outv;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_ID(inst_ID), .inst_EX(inst_EX),
        .RegWEn_EX(RegWEn_EX), .WBSel_EX(WBSel_EX), .PCSel_EX(PCSel_EX),
        .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
        .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID),
        .stall_ID_EX(stall_ID_EX), .stall_EX_MEM(stall_EX_MEM),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
        .bubble_MEM_WB(bubble_MEM_WB), .state(state),
        .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt),
        .flush_cnt(flush_cnt), .mem_err(mem_err)
    );

    assign outv = {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
                   flush_IF_ID, flush_ID_EX, bubble_MEM_WB};

    typedef struct {
        string            name;
        logic [31:0]      id;
        logic [31:0]      ex;
        logic             regwen;
        rv32_pkg::WBSel_t wbsel;
        logic             pcsel;
        logic             req;
        logic             rdy;
        logic [6:0]       exp_out;
        logic [1:0]       exp_state;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_ID = NOP; inst_EX = NOP; RegWEn_EX = 1'b0; WBSel_EX = rv32_pkg::WB_ALU;
        PCSel_EX = 1'b0; mem_req_MEM = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_lu();
        inst_ID = ADD_6_5_1; inst_EX = LW_X5; RegWEn_EX = 1'b1; WBSel_EX = rv32_pkg::WB_MEM;
    endtask

    // Reset pulse placed mid-low-phase, away from the rising edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"lu_rs1",      ADD_6_5_1,  LW_X5, 1'b1, rv32_pkg::WB_MEM, 1'b0, 1'b0, 1'b0, O_HZ,   2'b01};
        vecs[1]  = '{"lu_rs2",      ADD_6_1_5,  LW_X5, 1'b1, rv32_pkg::WB_MEM, 1'b0, 1'b0, 1'b0, O_HZ,   2'b01};
        vecs[2]  = '{"lui_nors1",   LUI_X5,     LW_X5, 1'b1, rv32_pkg::WB_MEM, 1'b0, 1'b0, 1'b0, O_NONE, 2'b00};
        vecs[3]  = '{"auipc_nors1", AUIPC_X5,   LW_X5, 1'b1, rv32_pkg::WB_MEM, 1'b0, 1'b0, 1'b0, O_NONE, 2'b00};
        vecs[4]  = '{"jal_nors1",   JAL_X5,     LW_X5, 1'b1, rv32_pkg::WB_MEM, 1'b0, 1'b0, 1'b0, O_NONE, 2'b00};
        vecs[5]  = '{"jalr_rs1",    JALR_6_5,   LW_X5, 1'b1, rv32_pkg::WB_MEM, 1'b0, 1'b0, 1'b0, O_HZ,   2'b01};
        vecs[6]  = '{"addi_rs1",    ADDI_6_5_1, LW_X5, 1'b1, rv32_pkg::WB_MEM, 1'b0, 1'b0, 1'b0, O_HZ,   2'b01};
        vecs[7]  = '{"addi_nors2",  ADDI_6_1_5, LW_X5, 1'b1, rv32_pkg::WB_MEM, 1'b0, 1'b0, 1'b0, O_NONE, 2'b00};
        vecs[8]  = '{"sw_rs2",      SW_5_1,     LW_X5, 1'b1, rv32_pkg::WB_MEM, 1'b0, 1'b0, 1'b0, O_HZ,   2'b01};
        vecs[9]  = '{"beq_rs2",     BEQ_1_5,    LW_X5, 1'b1, rv32_pkg::WB_MEM, 1'b0, 1'b0, 1'b0, O_HZ,   2'b01};
        vecs[10] = '{"rd_x0",       ADD_1_0_0,  LW_X0, 1'b1, rv32_pkg::WB_MEM, 1'b0, 1'b0, 1'b0, O_NONE, 2'b00};
        vecs[11] = '{"no_regwen",   ADD_6_5_1,  LW_X5, 1'b0, rv32_pkg::WB_MEM, 1'b0, 1'b0, 1'b0, O_NONE, 2'b00};
        vecs[12] = '{"wb_alu",      ADD_6_5_1,  LW_X5, 1'b1, rv32_pkg::WB_ALU, 1'b0, 1'b0, 1'b0, O_NONE, 2'b00};
        vecs[13] = '{"wb_pc",       ADD_6_5_1,  LW_X5, 1'b1, rv32_pkg::WB_PC,  1'b0, 1'b0, 1'b0, O_HZ,   2'b01};
        vecs[14] = '{"pcsel_hz",    ADD_6_5_1,  LW_X5, 1'b1, rv32_pkg::WB_MEM, 1'b1, 1'b0, 1'b0, O_FL,   2'b00};
        vecs[15] = '{"mw_only",     NOP,        NOP,   1'b0, rv32_pkg::WB_ALU, 1'b0, 1'b1, 1'b0, O_MW,   2'b10};
        vecs[16] = '{"req_ready",   NOP,        NOP,   1'b0, rv32_pkg::WB_ALU, 1'b0, 1'b1, 1'b1, O_NONE, 2'b00};
        vecs[17] = '{"mw_pc_hz",    ADD_6_5_1,  LW_X5, 1'b1, rv32_pkg::WB_MEM, 1'b1, 1'b1, 1'b0, O_MW,   2'b10};

        // Reset state, with outputs forced low even while a wait is requested
        #2;
        mem_req_MEM = 1'b1;
        #1;
        chk("rst_outputs", 32'(outv), 32'(O_NONE));
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cnt", 32'({lu_stall_cnt, mem_stall_cnt, flush_cnt, mem_err}), 32'd0);
        $display("reset: state=%0d outs=%b", state, outv);

        // Table-driven single-cycle vectors from RUN
        for (int i = 0; i < 18; i++) begin
            do_reset();
            inst_ID = vecs[i].id; inst_EX = vecs[i].ex; RegWEn_EX = vecs[i].regwen;
            WBSel_EX = vecs[i].wbsel; PCSel_EX = vecs[i].pcsel;
            mem_req_MEM = vecs[i].req; mem_ready = vecs[i].rdy;
            #1;
            chk({vecs[i].name, "_out"}, 32'(outv), 32'(vecs[i].exp_out));
            step();
            chk({vecs[i].name, "_state"}, 32'(state), 32'(vecs[i].exp_state));
            $display("vec %s: outs=%b state=%0d", vecs[i].name, outv, state);
        end

        // Load-use: 2 stall cycles, RUN -> LU_HOLD -> RUN
        do_reset();
        set_lu();
        #1;
        chk("lu_c0_out", 32'(outv), 32'(O_HZ));
        step();
        chk("lu_c0_state", 32'(state), 32'd1);
        @(negedge clk);
        inst_EX = NOP; RegWEn_EX = 1'b1; WBSel_EX = rv32_pkg::WB_ALU;
        #1;
        chk("lu_c1_out", 32'(outv), 32'(O_HZ));
        step();
        chk("lu_c1_state", 32'(state), 32'd0);
        chk("lu_cnt", 32'(lu_stall_cnt), 32'd2);
        @(negedge clk);
        #1;
        chk("lu_c2_out", 32'(outv), 32'(O_NONE));
        $display("load-use: lu_stall_cnt=%0d", lu_stall_cnt);

        // Unused source / x0: no stall, counters stay zero
        do_reset();
        inst_ID = 32'h0000_12B7; inst_EX = LW_X5; RegWEn_EX = 1'b1; WBSel_EX = rv32_pkg::WB_MEM;
        step();
        @(negedge clk);
        inst_ID = ADD_1_0_0; inst_EX = LW_X0;
        step();
        chk("unused_state", 32'(state), 32'd0);
        chk("unused_cnt", 32'({lu_stall_cnt, mem_stall_cnt, flush_cnt}), 32'd0);
        $display("unused/x0: state=%0d lu=%0d", state, lu_stall_cnt);

        // Redirect priority over a coincident hazard
        do_reset();
        set_lu();
        PCSel_EX = 1'b1;
        step();
        chk("redir_state", 32'(state), 32'd0);
        chk("redir_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("redir_lu_cnt", 32'(lu_stall_cnt), 32'd0);
        $display("redirect: flush_cnt=%0d lu=%0d", flush_cnt, lu_stall_cnt);

        // Memory wait inside LU_HOLD
        do_reset();
        set_lu();
        step();
        chk("lumw_state0", 32'(state), 32'd1);
        @(negedge clk);
        inst_EX = NOP; WBSel_EX = rv32_pkg::WB_ALU; mem_req_MEM = 1'b1; mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("lumw_mw%0d_out", c), 32'(outv), 32'(O_MW));
            step();
            chk($sformatf("lumw_mw%0d_state", c), 32'(state), 32'd2);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        chk("lumw_done_out", 32'(outv), 32'(O_NONE));
        step();
        chk("lumw_ret_state", 32'(state), 32'd1);
        @(negedge clk);
        mem_req_MEM = 1'b0; mem_ready = 1'b0;
        #1;
        chk("lumw_hold_out", 32'(outv), 32'(O_HZ));
        step();
        chk("lumw_end_state", 32'(state), 32'd0);
        chk("lumw_mem_cnt", 32'(mem_stall_cnt), 32'd3);
        chk("lumw_lu_cnt", 32'(lu_stall_cnt), 32'd2);
        $display("lu+mw: mem_stall_cnt=%0d lu_stall_cnt=%0d", mem_stall_cnt, lu_stall_cnt);

        // Reset in the middle of LU_HOLD: back to RUN, no residual stall
        do_reset();
        set_lu();
        step();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_lu_state", 32'(state), 32'd0);
        chk("rst_lu_out", 32'(outv), 32'(O_NONE));
        $display("reset in LU_HOLD: state=%0d", state);

        // Timeout into ERR after MEM_TIMEOUT consecutive wait cycles
        do_reset();
        mem_req_MEM = 1'b1; mem_ready = 1'b0;
        for (int c = 1; c <= MEM_TIMEOUT; c++) begin
            step();
            chk($sformatf("to_state%0d", c), 32'(state), (c == MEM_TIMEOUT) ? 32'd3 : 32'd2);
            chk($sformatf("to_err%0d", c), 32'(mem_err), (c == MEM_TIMEOUT) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("err_out", 32'(outv), 32'(O_MW));
        step();
        @(negedge clk);
        mem_req_MEM = 1'b0; mem_ready = 1'b0; PCSel_EX = 1'b1;
        #1;
        chk("err_out_pcsel", 32'(outv), 32'(O_MW));
        step();
        chk("err_sticky", 32'(state), 32'd3);
        chk("err_mem_cnt", 32'(mem_stall_cnt), 32'd3);
        $display("timeout: state=%0d mem_err=%0d mem_cnt=%0d", state, mem_err, mem_stall_cnt);
        do_reset();
        #1;
        chk("err_rst_state", 32'(state), 32'd0);
        chk("err_rst_merr", 32'(mem_err), 32'd0);
        chk("err_rst_cnt", 32'({lu_stall_cnt, mem_stall_cnt, flush_cnt}), 32'd0);
        $display("after reset: state=%0d mem_err=%0d", state, mem_err);

        // Saturation: 5 redirects with a 2-bit counter
        do_reset();
        PCSel_EX = 1'b1;
        step();
        step();
        chk("sat_flush2", 32'(flush_cnt), 32'd2);
        step();
        step();
        step();
        chk("sat_flush5", 32'(flush_cnt), 32'd3);
        $display("saturation: flush_cnt=%0d", flush_cnt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
